mac_seq_ctrl: RTL and testbench

- Command-driven sequencer for the 2-stage-pipelined 16-bit MAC (operand capture → product → accumulate/saturate; active-high stall).
- Accepts a dot-product job (length, mode, saturate flag) and streams operand pairs into the MAC.
- Issues the correct load/accumulate/saturate opcode sequence, waits out pipeline latency, and captures the final result/guard bits into a result register with a valid/ready handshake.
- Sits between the operand-fetch FIFO and the MAC instance. Shares the MAC's clk/reset_n.

---
 rtl/mac_seq_ctrl_if.sv | 47 ++++
 rtl/mac_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of the sequencer's job-command, operand-stream, MAC-drive and
// result-handshake signals. The controller takes the slave view; whatever
// drives jobs, supplies operands and hosts the MAC takes the master view.
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_mode;
  logic             cmd_sat;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [2:0]       mac_instruction;
  logic [15:0]      mac_multiplier;
  logic [15:0]      mac_multiplicand;
  logic             mac_stall;
  logic [31:0]      mac_result;
  logic [7:0]       mac_protect;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [7:0]       res_protect;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_len, cmd_mode, cmd_sat,
    input  op_valid, op_a, op_b,
    input  mac_result, mac_protect,
    input  res_ready,
    output cmd_ready, op_ready,
    output mac_instruction, mac_multiplier, mac_multiplicand, mac_stall,
    output res_valid, res_data, res_protect, busy
  );

  modport master (
    output cmd_valid, cmd_len, cmd_mode, cmd_sat,
    output op_valid, op_a, op_b,
    output mac_result, mac_protect,
    output res_ready,
    input  cmd_ready, op_ready,
    input  mac_instruction, mac_multiplier, mac_multiplicand, mac_stall,
    input  res_valid, res_data, res_protect, busy
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for the two-stage pipelined 16-bit MAC.
// Streams operand pairs with load/accumulate opcodes, optionally appends a
// saturate opcode, lets the MAC pipeline drain and then holds the final
// result and guard bits until the consumer takes them.
module mac_seq_ctrl #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  mac_seq_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_SAT   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD16  = 3'b001;
  localparam logic [2:0] OP_ACC16   = 3'b010;
  localparam logic [2:0] OP_SAT16   = 3'b011;
  localparam logic [2:0] OP_LOAD8X2 = 3'b101;
  localparam logic [2:0] OP_ACC8X2  = 3'b110;
  localparam logic [2:0] OP_SAT8X2  = 3'b111;

  localparam int              CNT_W      = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT - 1);

  logic [2:0]       state;
  logic [LEN_W-1:0] len_rem;
  logic             mode_r;
  logic             sat_r;
  logic             first_r;
  logic [CNT_W-1:0] drain_cnt;
  logic [31:0]      res_data_r;
  logic [7:0]       res_protect_r;

  logic take_op;
  logic last_op;

  assign take_op = (state == S_ISSUE) && bus.op_valid;
  assign last_op = take_op && (len_rem == LEN_W'(1));

  // Job sequencing: latch the command, count pairs and drain cycles, capture the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      len_rem       <= '0;
      mode_r        <= 1'b0;
      sat_r         <= 1'b0;
      first_r       <= 1'b0;
      drain_cnt     <= '0;
      res_data_r    <= '0;
      res_protect_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            mode_r    <= bus.cmd_mode;
            sat_r     <= bus.cmd_sat;
            first_r   <= 1'b1;
            len_rem   <= bus.cmd_len;
            drain_cnt <= '0;
            if (bus.cmd_len == '0) begin
              res_data_r    <= '0;
              res_protect_r <= '0;
              state         <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (take_op) begin
            first_r <= 1'b0;
            len_rem <= len_rem - LEN_W'(1);
            if (last_op) begin
              state <= sat_r ? S_SAT : S_DRAIN;
            end
          end
        end
        S_SAT: begin
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The clearing nops behind the last real opcode reach the accumulator
          // no earlier than this edge, so the sampled value is the job result.
          if (drain_cnt == DRAIN_LAST) begin
            res_data_r    <= bus.mac_result;
            res_protect_r <= bus.mac_protect;
            state         <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // MAC drive: operands pass straight through while issuing; a missing pair stalls the whole MAC.
  always_comb begin
    bus.mac_instruction  = OP_NOP;
    bus.mac_multiplier   = 16'h0000;
    bus.mac_multiplicand = 16'h0000;
    bus.mac_stall        = 1'b0;
    case (state)
      S_ISSUE: begin
        bus.mac_multiplier   = bus.op_a;
        bus.mac_multiplicand = bus.op_b;
        bus.mac_stall        = !bus.op_valid;
        if (first_r) begin
          bus.mac_instruction = mode_r ? OP_LOAD8X2 : OP_LOAD16;
        end else begin
          bus.mac_instruction = mode_r ? OP_ACC8X2 : OP_ACC16;
        end
      end
      S_SAT: begin
        bus.mac_instruction = mode_r ? OP_SAT8X2 : OP_SAT16;
      end
      default: begin
        bus.mac_instruction = OP_NOP;
      end
    endcase
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.op_ready    = (state == S_ISSUE);
  assign bus.res_valid   = (state == S_DONE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.res_data    = res_data_r;
  assign bus.res_protect = res_protect_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural two-stage MAC attached.
// Expected job results are queued when a job is launched and compared when
// the controller presents its result.
module tb_mac_seq_ctrl;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 3;

  logic clk;
  logic reset_n;

  mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

  mac_seq_ctrl #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [39:0] sb [$];
  logic [15:0] pa [16];
  logic [15:0] pb [16];

  // ---------------- behavioural MAC ----------------
  logic [2:0]  m1_op;
  logic [15:0] m1_a;
  logic [15:0] m1_b;
  logic [2:0]  m2_op;
  logic [39:0] m2_prod;
  logic [39:0] acc;
  logic        acc_dual;

  function automatic logic [39:0] mac_prod(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic signed [31:0] aw, bw, p;
    logic signed [15:0] ah, bh, al, bl, ph, pl;
    if (op[2]) begin
      ah = {{8{a[15]}}, a[15:8]};
      bh = {{8{b[15]}}, b[15:8]};
      al = {{8{a[7]}}, a[7:0]};
      bl = {{8{b[7]}}, b[7:0]};
      ph = ah * bh;
      pl = al * bl;
      return {{4{ph[15]}}, ph, {4{pl[15]}}, pl};
    end
    aw = {{16{a[15]}}, a};
    bw = {{16{b[15]}}, b};
    p  = aw * bw;
    return {{8{p[31]}}, p};
  endfunction

  function automatic logic [39:0] sat_wide(input logic [39:0] v);
    logic signed [39:0] s;
    logic signed [39:0] hi;
    logic signed [39:0] lo;
    s  = v;
    hi = 40'sd2147483647;
    lo = -40'sd2147483648;
    if (s > hi) return {v[39:32], 32'h7FFFFFFF};
    if (s < lo) return {v[39:32], 32'h80000000};
    return v;
  endfunction

  function automatic logic [19:0] sat_lane(input logic [19:0] v);
    logic signed [19:0] s;
    logic signed [19:0] hi;
    logic signed [19:0] lo;
    s  = v;
    hi = 20'sd32767;
    lo = -20'sd32768;
    if (s > hi) return {v[19:16], 16'h7FFF};
    if (s < lo) return {v[19:16], 16'h8000};
    return v;
  endfunction

  // Operand capture, product and accumulate stages; stall freezes all of them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m1_op <= 3'b000; m1_a <= '0; m1_b <= '0;
      m2_op <= 3'b000; m2_prod <= '0;
      acc <= '0; acc_dual <= 1'b0;
    end else if (!bus.mac_stall) begin
      m1_op   <= bus.mac_instruction;
      m1_a    <= bus.mac_multiplier;
      m1_b    <= bus.mac_multiplicand;
      m2_op   <= m1_op;
      m2_prod <= mac_prod(m1_op, m1_a, m1_b);
      case (m2_op)
        3'b000: acc <= '0;
        3'b001: begin acc <= m2_prod; acc_dual <= 1'b0; end
        3'b010: begin acc <= acc + m2_prod; acc_dual <= 1'b0; end
        3'b011: acc <= sat_wide(acc);
        3'b101: begin acc <= m2_prod; acc_dual <= 1'b1; end
        3'b110: begin
          acc <= {acc[39:20] + m2_prod[39:20], acc[19:0] + m2_prod[19:0]};
          acc_dual <= 1'b1;
        end
        3'b111: acc <= {sat_lane(acc[39:20]), sat_lane(acc[19:0])};
        default: acc <= acc;
      endcase
    end
  end

  assign bus.mac_result  = acc_dual ? {acc[35:20], acc[15:0]} : acc[31:0];
  assign bus.mac_protect = acc_dual ? {acc[39:36], acc[19:16]} : acc[39:32];

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b);
    pa[i] = a;
    pb[i] = b;
  endtask

  // Launches a job at the current negedge, feeds pairs (optionally with a
  // bubble of 'gaps' cycles before pair 'gap_at'), then checks result,
  // latency and optional backpressure for 'hold' cycles.
  task automatic run_job(input string name, input logic mode, input logic sat, input int n,
                         input int gap_at, input int gaps, input int exp_lat, input int hold,
                         input logic [31:0] exp_d, input logic [7:0] exp_p);
    int cyc, idx, g;
    logic [2:0] exp_op;
    logic [39:0] exp_r;
    sb.push_back({exp_p, exp_d});
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = n[7:0];
    bus.cmd_mode  = mode;
    bus.cmd_sat   = sat;
    #1;
    check({name, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    check({name, "_idle_op"}, bus.mac_instruction, 3'b000);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 1;
    idx = 0;
    g   = 0;
    while (idx < n && cyc < 100) begin
      exp_op = (idx == 0) ? (mode ? 3'b101 : 3'b001) : (mode ? 3'b110 : 3'b010);
      if (idx == gap_at && g < gaps) begin
        bus.op_valid = 1'b0;
        g++;
        #1;
        check({name, "_bubble_stall"}, bus.mac_stall, 1'b1);
        check({name, "_bubble_op"}, bus.mac_instruction, exp_op);
        check({name, "_bubble_a"}, bus.mac_multiplier, bus.op_a);
      end else begin
        bus.op_valid = 1'b1;
        bus.op_a     = pa[idx];
        bus.op_b     = pb[idx];
        #1;
        check({name, "_op"}, bus.mac_instruction, exp_op);
        check({name, "_stall"}, bus.mac_stall, 1'b0);
        check({name, "_op_ready"}, bus.op_ready, 1'b1);
        check({name, "_mult_b"}, bus.mac_multiplicand, pb[idx]);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.op_valid = 1'b0;
    if (sat && n > 0) begin
      #1;
      check({name, "_sat_op"}, bus.mac_instruction, mode ? 3'b111 : 3'b011);
      @(negedge clk);
      cyc++;
    end
    while (!bus.res_valid && cyc < 100) begin
      #1;
      check({name, "_drain_op"}, bus.mac_instruction, 3'b000);
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check({name, "_timeout"}, 1'b1, 1'b0);
    check({name, "_latency"}, cyc, exp_lat);
    exp_r = sb.pop_front();
    check({name, "_res_data"}, bus.res_data, exp_r[31:0]);
    check({name, "_res_protect"}, bus.res_protect, exp_r[39:32]);
    check({name, "_done_op"}, bus.mac_instruction, 3'b000);
    check({name, "_done_cmd_ready"}, bus.cmd_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 8'd5;
      @(negedge clk);
      check({name, "_hold_valid"}, bus.res_valid, 1'b1);
      check({name, "_hold_data"}, bus.res_data, exp_r[31:0]);
      check({name, "_hold_cmd_ready"}, bus.cmd_ready, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    check({name, "_back_idle"}, bus.cmd_ready, 1'b1);
    check({name, "_back_busy"}, bus.busy, 1'b0);
    check({name, "_back_valid"}, bus.res_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_mode  = 1'b0;
    bus.cmd_sat   = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) set_pair(i, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_data", bus.res_data, 32'h0);
    check("rst_res_protect", bus.res_protect, 8'h0);
    check("rst_op", bus.mac_instruction, 3'b000);
    check("rst_stall", bus.mac_stall, 1'b0);
    check("rst_mult", {bus.mac_multiplier, bus.mac_multiplicand}, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    set_pair(0, 16'd2, 16'd3);
    set_pair(1, 16'hFFFC, 16'd5);
    set_pair(2, 16'd100, 16'd100);
    run_job("m0_plain", 1'b0, 1'b0, 3, -1, 0, 7, 0, 32'h00002702, 8'h00);

    for (int i = 0; i < 4; i++) set_pair(i, 16'h8000, 16'h8000);
    run_job("m0_sat", 1'b0, 1'b1, 4, -1, 0, 9, 0, 32'h7FFFFFFF, 8'h01);
    run_job("m0_wrap", 1'b0, 1'b0, 4, -1, 0, 8, 0, 32'h00000000, 8'h01);

    for (int i = 0; i < 3; i++) set_pair(i, 16'h7F02, 16'h7F03);
    run_job("m1_sat", 1'b1, 1'b1, 3, -1, 0, 8, 0, 32'h7FFF0012, 8'h00);
    run_job("m1_hold", 1'b1, 1'b0, 3, -1, 0, 7, 5, 32'hBD030012, 8'h00);

    set_pair(0, 16'd2, 16'd3);
    set_pair(1, 16'hFFFC, 16'd5);
    set_pair(2, 16'd100, 16'd100);
    run_job("bubble", 1'b0, 1'b0, 3, 1, 2, 9, 0, 32'h00002702, 8'h00);

    run_job("len0", 1'b0, 1'b0, 0, -1, 0, 1, 0, 32'h00000000, 8'h00);

    // Reset in the middle of a 10-pair job.
    for (int i = 0; i < 10; i++) set_pair(i, 16'd7, 16'd9);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd10;
    bus.cmd_mode  = 1'b0;
    bus.cmd_sat   = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = pa[i];
      bus.op_b     = pb[i];
      @(negedge clk);
    end
    #1;
    check("mid_busy", bus.busy, 1'b1);
    bus.op_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    check("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("mid_rst_res_valid", bus.res_valid, 1'b0);
    check("mid_rst_op", bus.mac_instruction, 3'b000);
    check("mid_rst_stall", bus.mac_stall, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    set_pair(0, 16'd2, 16'd3);
    set_pair(1, 16'hFFFC, 16'd5);
    set_pair(2, 16'd100, 16'd100);
    run_job("post_rst", 1'b0, 1'b0, 3, -1, 0, 7, 0, 32'h00002702, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
